adder_error_monitor: RTL and testbench

Sequential checker that sits on the result side of any 16-bit adder under evaluation (CLA or approximate variants). It accepts operand/result samples through a valid/ready handshake and recomputes the exact sum. It accumulates error statistics over a programmed run: sample count, erroneous-sample count, maximum error distance and sum of error distances. A host or bench then reads these to compute error rate and mean error distance.

---
 rtl/approx_adder_pkg.sv | 25 ++
 rtl/adder_err_stage.sv | 97 +++++++++
 rtl/adder_error_monitor.sv | 111 +++++++++++
 tb/tb_adder_error_monitor.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/approx_adder_pkg.sv
// approx_adder_pkg: shared types and helpers for the adder error monitor.
//   state_t   - monitor FSM states (IDLE, RUN, DRAIN, DONE)
//   DEF_WIDTH - default operand width of the adder under evaluation
//   abs_diff  - unsigned absolute difference, used as the error distance
package approx_adder_pkg;

    localparam int DEF_WIDTH = 16;

    // abs_diff works on a wide container so one helper serves any operand
    // width; callers zero-extend into it and truncate the result back.
    localparam int ABS_W = 64;
    typedef logic [ABS_W-1:0] wide_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic wide_t abs_diff(input wide_t x, input wide_t y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/adder_err_stage.sv
// adder_err_stage: two-stage error datapath of the adder error monitor.
//   Stage 1 registers the exact sum a+b+cin and the reported {cout,sum}.
//   Stage 2 computes the error distance and updates the statistics.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   clear                 zero all statistics and the stage-1 slot
//   accept                a sample is taken this cycle
//   a, b, cin             operands applied to the adder under test
//   approx_sum/_cout      result reported by the adder under test
//   sample_cnt, err_cnt   samples seen / samples with nonzero distance
//   max_ed, sum_ed        largest distance / saturating sum of distances
module adder_err_stage
    import approx_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 32,
    parameter int ACC_W = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             accept,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] approx_sum,
    input  logic             approx_cout,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [WIDTH:0]   max_ed,
    output logic [ACC_W-1:0] sum_ed
);

    localparam int ED_W  = WIDTH + 1;
    localparam int SUM_W = ACC_W + 1;

    logic            s1_valid;
    logic [ED_W-1:0] exact_d;
    logic [ED_W-1:0] exact_q;
    logic [ED_W-1:0] approx_q;
    logic [ED_W-1:0] ed;
    logic [SUM_W-1:0] sum_wide;

    // Full-width exact sum: the carry-out is part of the comparison.
    assign exact_d = ED_W'(a) + ED_W'(b) + ED_W'(cin);

    assign ed = ED_W'(abs_diff(wide_t'(exact_q), wide_t'(approx_q)));

    // One extra bit catches the overflow that triggers saturation.
    assign sum_wide = {1'b0, sum_ed} + SUM_W'(ed);

    // Stage-1 valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            s1_valid <= 1'b0;
        end else if (clear) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
        end
    end

    // Stage-1 payload.
    // NOTE: payload registers are not reset; they are only consumed while
    // s1_valid is set, so resetting them would add fan-out for nothing.
    always_ff @(posedge clk) begin
        if (accept) begin
            exact_q  <= exact_d;
            approx_q <= {approx_cout, approx_sum};
        end
    end

    // Stage 2: statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            max_ed     <= '0;
            sum_ed     <= '0;
        end else if (clear) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            max_ed     <= '0;
            sum_ed     <= '0;
        end else if (s1_valid) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
            err_cnt    <= err_cnt + CNT_W'(ed != '0);
            if (ed > max_ed) begin
                max_ed <= ed;
            end
            sum_ed <= sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/adder_error_monitor.sv
// adder_error_monitor: collects error statistics for a 16-bit adder under
// evaluation over a run of num_samples operand/result samples.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, num_samples    begin a run of num_samples (IDLE/DONE only)
//   in_valid, in_ready    sample handshake; accept = in_valid && in_ready
//   a, b, cin             operands applied to the adder under test
//   approx_sum/_cout      result reported by the adder under test
//   busy, done            run in progress / statistics final
//   sample_cnt, err_cnt   samples accepted / samples with nonzero distance
//   max_ed, sum_ed        largest distance / saturating sum of distances
module adder_error_monitor
    import approx_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 32,
    parameter int ACC_W = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] approx_sum,
    input  logic             approx_cout,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [WIDTH:0]   max_ed,
    output logic [ACC_W-1:0] sum_ed
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] n_target;
    logic [CNT_W-1:0] acc_cnt;
    logic             accept;
    logic             start_ok;
    logic             last_accept;

    assign in_ready    = (state == RUN);
    assign busy        = (state == RUN) || (state == DRAIN);
    assign done        = (state == DONE);
    assign accept      = in_valid && in_ready;
    assign start_ok    = start && ((state == IDLE) || (state == DONE));
    assign last_accept = accept && ((acc_cnt + CNT_W'(1)) == n_target);

    always_comb begin
        // NOTE: default first so every path assigns state_nxt; otherwise a
        // latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = (num_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_accept) begin
                    state_nxt = DRAIN;
                end
            end
            // No accepts happen in DRAIN, so the single in-flight sample
            // retires on this edge and the statistics are final after it.
            DRAIN:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            n_target <= '0;
            acc_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                n_target <= num_samples;
                acc_cnt  <= '0;
            end else if (accept) begin
                acc_cnt <= acc_cnt + CNT_W'(1);
            end
        end
    end

    adder_err_stage #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .ACC_W (ACC_W)
    ) u_stage (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (start_ok),
        .accept      (accept),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .approx_sum  (approx_sum),
        .approx_cout (approx_cout),
        .sample_cnt  (sample_cnt),
        .err_cnt     (err_cnt),
        .max_ed      (max_ed),
        .sum_ed      (sum_ed)
    );

endmodule

// File: tb/tb_adder_error_monitor.sv
// tb_adder_error_monitor: directed bench for adder_error_monitor. A second
// instance with ACC_W=20 shares all inputs to exercise sum_ed saturation.
module tb_adder_error_monitor;
    import approx_adder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] num_samples = '0;
    logic        in_valid = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic [15:0] approx_sum = '0;
    logic        approx_cout = 1'b0;

    logic        in_ready, busy, done;
    logic [31:0] sample_cnt, err_cnt;
    logic [16:0] max_ed;
    logic [47:0] sum_ed;

    logic        s_in_ready, s_busy, s_done;
    logic [31:0] s_sample_cnt, s_err_cnt;
    logic [16:0] s_max_ed;
    logic [19:0] s_sum_ed;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    adder_error_monitor dut (
        .clk (clk), .rst_n (rst_n), .start (start), .num_samples (num_samples),
        .in_valid (in_valid), .in_ready (in_ready), .a (a), .b (b), .cin (cin),
        .approx_sum (approx_sum), .approx_cout (approx_cout), .busy (busy),
        .done (done), .sample_cnt (sample_cnt), .err_cnt (err_cnt),
        .max_ed (max_ed), .sum_ed (sum_ed)
    );

    adder_error_monitor #(.ACC_W(20)) dut_sat (
        .clk (clk), .rst_n (rst_n), .start (start), .num_samples (num_samples),
        .in_valid (in_valid), .in_ready (s_in_ready), .a (a), .b (b), .cin (cin),
        .approx_sum (approx_sum), .approx_cout (approx_cout), .busy (s_busy),
        .done (s_done), .sample_cnt (s_sample_cnt), .err_cnt (s_err_cnt),
        .max_ed (s_max_ed), .sum_ed (s_sum_ed)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns on the negedge after start's edge.
    task automatic start_run(input int n);
        start       = 1'b1;
        num_samples = 32'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns on the negedge just after the accept edge.
    task automatic push(input logic [15:0] a_i, input logic [15:0] b_i, input logic cin_i,
                        input logic [15:0] s_i, input logic co_i);
        int waits = 0;
        a = a_i; b = b_i; cin = cin_i; approx_sum = s_i; approx_cout = co_i;
        in_valid = 1'b1;
        while (!in_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        check("push_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("rst_state", 64'(dut.state), 64'(IDLE));
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_busy_done", 64'({busy, done}), 64'd0);
        check("rst_stats", 64'(sample_cnt | err_cnt | 32'(max_ed) | 32'(sum_ed)), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Exact model, 6 samples, all correct
        start_run(6);
        check("ex_busy", 64'(busy), 64'd1);
        push(16'd120,   16'd100,  1'b1, 16'd221,  1'b0);
        check("ex_latency", 64'(sample_cnt), 64'd0);
        push(16'd20,    16'd3,    1'b0, 16'd23,   1'b0);
        push(16'd300,   16'd160,  1'b1, 16'd461,  1'b0);
        push(16'd1038,  16'd1024, 1'b0, 16'd2062, 1'b0);
        push(16'd65534, 16'd1,    1'b0, 16'd65535,1'b0);
        push(16'd65535, 16'd1,    1'b0, 16'd0,    1'b1);
        check("ex_ready_low", 64'(in_ready), 64'd0);
        check("ex_not_done_yet", 64'(done), 64'd0);
        check("ex_cnt_pre", 64'(sample_cnt), 64'd5);
        @(negedge clk);
        check("ex_done", 64'(done), 64'd1);
        check("ex_busy_low", 64'(busy), 64'd0);
        check("ex_cnt", 64'(sample_cnt), 64'd6);
        check("ex_err", 64'(err_cnt), 64'd0);
        check("ex_max", 64'(max_ed), 64'd0);
        check("ex_sum", 64'(sum_ed), 64'd0);

        // Injected errors, restart from DONE
        start_run(2);
        check("inj_clear_cnt", 64'(sample_cnt), 64'd0);
        check("inj_done_low", 64'(done), 64'd0);
        push(16'd65535, 16'd1,   1'b0, 16'd0,   1'b0);
        push(16'd120,   16'd100, 1'b1, 16'd219, 1'b0);
        check("inj_mid_max", 64'(max_ed), 64'd65536);
        wait_done("inj");
        check("inj_err", 64'(err_cnt), 64'd2);
        check("inj_max", 64'(max_ed), 64'd65536);
        check("inj_sum", 64'(sum_ed), 64'd65538);

        // Saturation: 17 samples of ED=65536
        start_run(17);
        for (int i = 0; i < 17; i++) push(16'd65535, 16'd1, 1'b0, 16'd0, 1'b0);
        wait_done("sat");
        check("sat_sum20", 64'(s_sum_ed), 64'd1048575);
        check("sat_err20", 64'(s_err_cnt), 64'd17);
        check("sat_sum48", 64'(sum_ed), 64'd1114112);
        check("sat_max", 64'(max_ed), 64'd65536);

        // Backpressure and gaps
        begin
            int pat[11] = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 1, 1};
            int acc = 0;
            start_run(4);
            for (int i = 0; i < 11; i++) begin
                in_valid = pat[i][0];
                a = 16'(i); b = 16'd0; cin = 1'b0;
                approx_sum = 16'(i); approx_cout = 1'b0;
                check($sformatf("bp_ready_%0d", i), 64'(in_ready), 64'(acc < 4));
                if (in_valid && in_ready) acc++;
                @(negedge clk);
            end
            in_valid = 1'b0;
            check("bp_accepts", 64'(acc), 64'd4);
            check("bp_cnt", 64'(sample_cnt), 64'd4);
            check("bp_err", 64'(err_cnt), 64'd0);
            check("bp_done", 64'(done), 64'd1);
        end

        // Zero-length run from DONE, then restart
        start_run(0);
        check("zero_done", 64'(done), 64'd1);
        check("zero_busy", 64'(busy), 64'd0);
        check("zero_cnt", 64'(sample_cnt), 64'd0);
        start_run(2);
        check("re_done_low", 64'(done), 64'd0);
        check("re_ready", 64'(in_ready), 64'd1);
        push(16'd7, 16'd8, 1'b0, 16'd14, 1'b0);
        push(16'd1, 16'd1, 1'b1, 16'd3,  1'b0);
        wait_done("re");
        check("re_cnt", 64'(sample_cnt), 64'd2);
        check("re_err", 64'(err_cnt), 64'd1);
        check("re_sum", 64'(sum_ed), 64'd1);

        // Reset mid-run: 3 of 10 accepts, asynchronous reset between edges
        start_run(10);
        for (int i = 0; i < 3; i++) push(16'(i), 16'd5, 1'b0, 16'd0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mr_state", 64'(dut.state), 64'(IDLE));
        check("mr_flags", 64'({in_ready, busy, done}), 64'd0);
        check("mr_stats", 64'(sample_cnt | err_cnt | 32'(max_ed) | 32'(sum_ed)), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mr_idle_ready", 64'(in_ready), 64'd0);
        start_run(1);
        push(16'd40, 16'd2, 1'b0, 16'd42, 1'b0);
        wait_done("mr_new");
        check("mr_new_cnt", 64'(sample_cnt), 64'd1);
        check("mr_new_err", 64'(err_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
